// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU writeback stage.
//   csr_op_e        CSR access kind (none/write/set/clear)
//   CSR_* addresses fflags / frm / fcsr
//   FLAG_* indices  bit positions inside fflags {NV,DZ,OF,UF,NX}
//   FRM_* codes     rounding-mode encodings
//   wb_entry_t      one buffered writeback entry
//   buf_state_e     occupancy of the 2-entry skid buffer
package fpu_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int FLAGS_W = 5;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [2:0] FRM_RNE = 3'd0;
   localparam logic [2:0] FRM_RTZ = 3'd1;
   localparam logic [2:0] FRM_RDN = 3'd2;
   localparam logic [2:0] FRM_RUP = 3'd3;
   localparam logic [2:0] FRM_RMM = 3'd4;
   localparam logic [2:0] FRM_DYN = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0]    data;
      logic [RADDR_W-1:0] rd;
      logic               is_x;
      logic [FLAGS_W-1:0] flags;
      logic               flags_en;
   } wb_entry_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   // Read-modify-write result of a CSR op on an 8-bit fcsr-sized field.
   function automatic logic [7:0] csr_apply(input csr_op_e op,
                                            input logic [7:0] cur,
                                            input logic [7:0] operand);
      logic [7:0] res;
      case (op)
         CSR_WRITE: res = operand;
         CSR_SET:   res = cur | operand;
         CSR_CLEAR: res = cur & ~operand;
         default:   res = cur;
      endcase
      return res;
   endfunction

   // 101/110/111 are reserved rounding-mode encodings.
   function automatic logic frm_reserved(input logic [2:0] mode);
      return (mode == 3'd5) || (mode == 3'd6) || (mode == 3'd7);
   endfunction

endpackage

// File: rtl/fp_csr_file.sv
// fp_csr_file: RV32F fflags/frm state.
//   csr_op/csr_addr/csr_wdata  CSR access request
//   ret_valid/ret_flags        flags of the op retiring this cycle
//   csr_hit/csr_rdata          decode hit and read value (retiring flags bypassed)
//   frm/frm_invalid/fflags     current state
module fp_csr_file
   import fpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   input  logic               ret_valid,
   input  logic [FLAGS_W-1:0] ret_flags,
   output logic               csr_hit,
   output logic [XLEN-1:0]    csr_rdata,
   output logic [2:0]         frm,
   output logic               frm_invalid,
   output logic [FLAGS_W-1:0] fflags
);

   logic [FLAGS_W-1:0] fflags_q, fflags_d;
   logic [2:0]         frm_q, frm_d;
   logic [FLAGS_W-1:0] ret_s;
   logic [FLAGS_W-1:0] flags_byp_s;
   logic [7:0]         cur_s;
   logic [7:0]         res_s;
   csr_op_e            op_s;
   logic               unused_wdata_s;

   assign unused_wdata_s = ^csr_wdata[XLEN-1:8];

   // Decode, bypass of retiring flags, and next-state computation.
   always_comb begin
      op_s        = csr_op_e'(csr_op);
      ret_s       = ret_valid ? ret_flags : {FLAGS_W{1'b0}};
      // The retiring op is older than the CSR access, so it is seen first.
      flags_byp_s = fflags_q | ret_s;
      csr_hit     = 1'b0;
      cur_s       = 8'h00;
      case (csr_addr)
         CSR_FFLAGS: begin
            csr_hit = 1'b1;
            cur_s   = {3'b000, flags_byp_s};
         end
         CSR_FRM: begin
            csr_hit = 1'b1;
            cur_s   = {5'b00000, frm_q};
         end
         CSR_FCSR: begin
            csr_hit = 1'b1;
            cur_s   = {frm_q, flags_byp_s};
         end
         default: begin
            csr_hit = 1'b0;
            cur_s   = 8'h00;
         end
      endcase
      csr_rdata = {{(XLEN-8){1'b0}}, cur_s};
      res_s     = csr_apply(op_s, cur_s, csr_wdata[7:0]);

      fflags_d = flags_byp_s;
      frm_d    = frm_q;
      if (csr_hit && (op_s != CSR_NONE)) begin
         case (csr_addr)
            // Retiring flags are re-ORed so a clear cannot erase them.
            CSR_FFLAGS: fflags_d = res_s[4:0] | ret_s;
            CSR_FRM:    frm_d    = res_s[2:0];
            CSR_FCSR: begin
               fflags_d = res_s[4:0] | ret_s;
               frm_d    = res_s[7:5];
            end
            default: begin
               fflags_d = flags_byp_s;
               frm_d    = frm_q;
            end
         endcase
      end else begin
         fflags_d = flags_byp_s;
         frm_d    = frm_q;
      end
   end

   // fflags / frm state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags_q <= {FLAGS_W{1'b0}};
         frm_q    <= FRM_RNE;
      end else begin
         fflags_q <= fflags_d;
         frm_q    <= frm_d;
      end
   end

   assign fflags      = fflags_q;
   assign frm         = frm_q;
   assign frm_invalid = frm_reserved(frm_q);

endmodule

// File: rtl/fpu_wb_stage.sv
// fpu_wb_stage: FPU writeback stage.
//   ex_*     result from FPU/convert, handshake ex_valid/ex_ready
//   stall    downstream hold, flush discards everything buffered and incoming
//   wb_*     head entry, steered to integer (wb_to_x) or FP (wb_to_f) regfile
//   csr_*    fcsr access port; frm/frm_invalid/fflags current fcsr state
module fpu_wb_stage
   import fpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [XLEN-1:0]    ex_res,
   input  logic               ex_cmp,
   input  logic               ex_cmp_op,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               ex_rd_is_x,
   input  logic [FLAGS_W-1:0] ex_fflags,
   input  logic               ex_flags_en,
   input  logic               stall,
   input  logic               flush,
   output logic               wb_valid,
   output logic [XLEN-1:0]    wb_data,
   output logic [RADDR_W-1:0] wb_rd,
   output logic               wb_to_x,
   output logic               wb_to_f,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic               csr_hit,
   output logic [XLEN-1:0]    csr_rdata,
   output logic [2:0]         frm,
   output logic               frm_invalid,
   output logic [FLAGS_W-1:0] fflags
);

   buf_state_e state_q, state_d;
   wb_entry_t  head_q, head_d;
   wb_entry_t  tail_q, tail_d;
   logic       ready_q, ready_d;
   wb_entry_t  new_s;
   logic       accept_s;
   logic       pop_s;

   assign wb_valid = (state_q != BUF_EMPTY) && !flush;
   assign pop_s    = wb_valid && !stall;
   assign accept_s = ex_valid && ready_q && !flush;

   // Build the incoming entry; compares return a zero-extended boolean.
   always_comb begin
      new_s.data     = ex_cmp_op ? {{(XLEN-1){1'b0}}, ex_cmp} : ex_res;
      new_s.rd       = ex_rd;
      new_s.is_x     = ex_rd_is_x;
      new_s.flags    = ex_fflags;
      new_s.flags_en = ex_flags_en;
   end

   // Occupancy FSM and entry shifting (head is always the oldest entry).
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop_s) begin
         head_d = tail_q;
      end else begin
         head_d = head_q;
      end
      if (accept_s) begin
         // New entry lands in the head slot if the buffer is (becoming) empty.
         if ((state_q == BUF_EMPTY) || ((state_q == BUF_ONE) && pop_s)) begin
            head_d = new_s;
         end else begin
            tail_d = new_s;
         end
      end else begin
         tail_d = tail_q;
      end
      if (flush) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: state_d = accept_s ? BUF_ONE : BUF_EMPTY;
            BUF_ONE: begin
               if (accept_s && !pop_s) begin
                  state_d = BUF_TWO;
               end else if (!accept_s && pop_s) begin
                  state_d = BUF_EMPTY;
               end else begin
                  state_d = BUF_ONE;
               end
            end
            BUF_TWO:   state_d = pop_s ? BUF_ONE : BUF_TWO;
            default:   state_d = BUF_EMPTY;
         endcase
      end
      ready_d = (state_d != BUF_TWO);
   end

   // Buffer state, entries and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         ready_q <= ready_d;
      end
   end

   assign ex_ready = ready_q;
   assign wb_data  = head_q.data;
   assign wb_rd    = head_q.rd;
   assign wb_to_x  = wb_valid && head_q.is_x;
   assign wb_to_f  = wb_valid && !head_q.is_x;

   fp_csr_file u_csr (
      .clk         (clk),
      .rst_n       (rst_n),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .ret_valid   (pop_s && head_q.flags_en),
      .ret_flags   (head_q.flags),
      .csr_hit     (csr_hit),
      .csr_rdata   (csr_rdata),
      .frm         (frm),
      .frm_invalid (frm_invalid),
      .fflags      (fflags)
   );

endmodule

// File: tb/tb_fpu_wb_stage.sv
module tb_fpu_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_res;
   logic        ex_cmp, ex_cmp_op;
   logic [4:0]  ex_rd;
   logic        ex_rd_is_x;
   logic [4:0]  ex_fflags;
   logic        ex_flags_en;
   logic        stall, flush;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_to_x, wb_to_f;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_hit;
   logic [31:0] csr_rdata;
   logic [2:0]  frm;
   logic        frm_invalid;
   logic [4:0]  fflags;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fpu_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_res(ex_res), .ex_cmp(ex_cmp), .ex_cmp_op(ex_cmp_op), .ex_rd(ex_rd),
      .ex_rd_is_x(ex_rd_is_x), .ex_fflags(ex_fflags), .ex_flags_en(ex_flags_en),
      .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_to_x(wb_to_x), .wb_to_f(wb_to_f), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_hit(csr_hit),
      .csr_rdata(csr_rdata), .frm(frm), .frm_invalid(frm_invalid), .fflags(fflags)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [4:0] rd, input logic [31:0] res,
                           input logic [4:0] fl, input logic fl_en, input logic is_x);
      ex_valid    = 1'b1;
      ex_rd       = rd;
      ex_res      = res;
      ex_fflags   = fl;
      ex_flags_en = fl_en;
      ex_rd_is_x  = is_x;
      ex_cmp_op   = 1'b0;
      ex_cmp      = 1'b0;
   endtask

   task automatic test_reset();
      csr_op = 2'b01; csr_addr = 12'h003; csr_wdata = 32'h0000_0045;
      step();
      csr_op = 2'b00;
      stall = 1'b1;
      drive_op(5'd7, 32'h1234_5678, 5'b00000, 1'b0, 1'b0);
      step();
      drive_op(5'd8, 32'h9ABC_DEF0, 5'b00000, 1'b0, 1'b0);
      step();
      ex_valid = 1'b0;
      vectors++;
      if (ex_ready !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 5'd7) begin
         miscompares++;
         $display("FAIL reset_fill: ex_ready=%b wb_valid=%b wb_rd=%0d, want 0 1 7", ex_ready, wb_valid, wb_rd);
      end
      vectors++;
      if (frm !== 3'b010 || fflags !== 5'b00101) begin
         miscompares++;
         $display("FAIL reset_precsr: frm=%b fflags=%b, want 010 00101", frm, fflags);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || fflags !== 5'b0 || frm !== 3'b0 ||
          wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_to_x !== 1'b0 || wb_to_f !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async: wb_valid=%b ex_ready=%b fflags=%b frm=%b wb_data=%h wb_rd=%0d, want 0 1 0 0 0 0",
                  wb_valid, ex_ready, fflags, frm, wb_data, wb_rd);
      end
      step();
      rst_n = 1'b1;
      stall = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      stall = 1'b1;
      drive_op(5'd1, 32'h0000_0011, 5'b0, 1'b0, 1'b0);
      step();
      drive_op(5'd2, 32'h0000_0022, 5'b0, 1'b0, 1'b0);
      step();
      drive_op(5'd3, 32'h0000_0033, 5'b0, 1'b0, 1'b0);
      step();
      vectors++;
      if (ex_ready !== 1'b0 || wb_rd !== 5'd1 || wb_data !== 32'h11) begin
         miscompares++;
         $display("FAIL b2b_full: ex_ready=%b wb_rd=%0d wb_data=%h, want 0 1 00000011", ex_ready, wb_rd, wb_data);
      end
      stall = 1'b0;
      vectors++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_to_f !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ret1: wb_valid=%b wb_rd=%0d wb_to_f=%b, want 1 1 1", wb_valid, wb_rd, wb_to_f);
      end
      step();
      vectors++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || ex_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ret2: wb_valid=%b wb_rd=%0d ex_ready=%b, want 1 2 1", wb_valid, wb_rd, ex_ready);
      end
      step();
      ex_valid = 1'b0;
      vectors++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h33) begin
         miscompares++;
         $display("FAIL b2b_ret3: wb_valid=%b wb_rd=%0d wb_data=%h, want 1 3 00000033", wb_valid, wb_rd, wb_data);
      end
      step();
      vectors++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_empty: wb_valid=%b ex_ready=%b, want 0 1", wb_valid, ex_ready);
      end
   endtask

   task automatic test_cmp_steer();
      drive_op(5'd9, 32'hDEAD_BEEF, 5'b0, 1'b0, 1'b1);
      ex_cmp_op = 1'b1;
      ex_cmp    = 1'b1;
      step();
      drive_op(5'd10, 32'hCAFE_F00D, 5'b0, 1'b0, 1'b0);
      vectors++;
      if (wb_data !== 32'h0000_0001 || wb_to_x !== 1'b1 || wb_to_f !== 1'b0 || wb_rd !== 5'd9) begin
         miscompares++;
         $display("FAIL cmp_x: wb_data=%h wb_to_x=%b wb_to_f=%b wb_rd=%0d, want 00000001 1 0 9",
                  wb_data, wb_to_x, wb_to_f, wb_rd);
      end
      step();
      ex_valid = 1'b0;
      vectors++;
      if (wb_data !== 32'hCAFE_F00D || wb_to_x !== 1'b0 || wb_to_f !== 1'b1) begin
         miscompares++;
         $display("FAIL res_f: wb_data=%h wb_to_x=%b wb_to_f=%b, want cafef00d 0 1", wb_data, wb_to_x, wb_to_f);
      end
      step();
   endtask

   task automatic test_flags();
      drive_op(5'd4, 32'h0, 5'b00001, 1'b1, 1'b0);
      step();
      drive_op(5'd5, 32'h0, 5'b10000, 1'b1, 1'b0);
      csr_addr = 12'h001;
      #1;
      vectors++;
      if (fflags !== 5'b00000 || csr_rdata !== 32'h0000_0001) begin
         miscompares++;
         $display("FAIL flag_bypass: fflags=%b csr_rdata=%h, want 00000 00000001", fflags, csr_rdata);
      end
      step();
      ex_valid = 1'b0;
      step();
      vectors++;
      if (fflags !== 5'b10001) begin
         miscompares++;
         $display("FAIL flag_accrue: fflags=%b, want 10001", fflags);
      end
      stall = 1'b1;
      drive_op(5'd6, 32'h0, 5'b01000, 1'b1, 1'b0);
      step();
      flush = 1'b1;
      drive_op(5'd7, 32'h0, 5'b00100, 1'b1, 1'b0);
      stall = 1'b0;
      #1;
      vectors++;
      if (wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_wbv: wb_valid=%b, want 0", wb_valid);
      end
      step();
      flush = 1'b0;
      ex_valid = 1'b0;
      #1;
      vectors++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || fflags !== 5'b10001) begin
         miscompares++;
         $display("FAIL flush_flags: wb_valid=%b ex_ready=%b fflags=%b, want 0 1 10001", wb_valid, ex_ready, fflags);
      end
      step();
      vectors++;
      if (fflags !== 5'b10001) begin
         miscompares++;
         $display("FAIL flush_later: fflags=%b, want 10001", fflags);
      end
   endtask

   task automatic test_csr();
      csr_op = 2'b01; csr_addr = 12'h003; csr_wdata = 32'h0000_00FF;
      #1;
      vectors++;
      if (csr_hit !== 1'b1) begin
         miscompares++;
         $display("FAIL fcsr_hit: csr_hit=%b, want 1", csr_hit);
      end
      step();
      csr_op = 2'b00;
      #1;
      vectors++;
      if (frm !== 3'b111 || fflags !== 5'b11111 || frm_invalid !== 1'b1 || csr_rdata !== 32'h0000_00FF) begin
         miscompares++;
         $display("FAIL fcsr_write: frm=%b fflags=%b frm_invalid=%b csr_rdata=%h, want 111 11111 1 000000ff",
                  frm, fflags, frm_invalid, csr_rdata);
      end
      drive_op(5'd11, 32'h0, 5'b00001, 1'b1, 1'b0);
      step();
      ex_valid = 1'b0;
      csr_op = 2'b11; csr_addr = 12'h001; csr_wdata = 32'h0000_001F;
      step();
      csr_op = 2'b00;
      vectors++;
      if (fflags !== 5'b00001) begin
         miscompares++;
         $display("FAIL clear_retire: fflags=%b, want 00001", fflags);
      end
   endtask

   task automatic test_frm_unhit();
      csr_op = 2'b01; csr_addr = 12'h002; csr_wdata = 32'h0000_0002;
      step();
      csr_op = 2'b00;
      #1;
      vectors++;
      if (frm !== 3'b010 || frm_invalid !== 1'b0 || fflags !== 5'b00001 || csr_rdata !== 32'h0000_0002) begin
         miscompares++;
         $display("FAIL frm_write: frm=%b frm_invalid=%b fflags=%b csr_rdata=%h, want 010 0 00001 00000002",
                  frm, frm_invalid, fflags, csr_rdata);
      end
      csr_op = 2'b01; csr_addr = 12'h004; csr_wdata = 32'hFFFF_FFFF;
      #1;
      vectors++;
      if (csr_hit !== 1'b0 || csr_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL unhit: csr_hit=%b csr_rdata=%h, want 0 00000000", csr_hit, csr_rdata);
      end
      step();
      csr_op = 2'b10; csr_addr = 12'h001; csr_wdata = 32'h0000_0004;
      vectors++;
      if (frm !== 3'b010 || fflags !== 5'b00001) begin
         miscompares++;
         $display("FAIL unhit_state: frm=%b fflags=%b, want 010 00001", frm, fflags);
      end
      step();
      csr_op = 2'b00;
      vectors++;
      if (fflags !== 5'b00101 || frm !== 3'b010) begin
         miscompares++;
         $display("FAIL set_flags: fflags=%b frm=%b, want 00101 010", fflags, frm);
      end
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_res = 32'h0; ex_cmp = 1'b0; ex_cmp_op = 1'b0;
      ex_rd = 5'd0; ex_rd_is_x = 1'b0; ex_fflags = 5'd0; ex_flags_en = 1'b0;
      stall = 1'b0; flush = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
      step();
      step();
      vectors++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || fflags !== 5'b0 || frm !== 3'b0) begin
         miscompares++;
         $display("FAIL reset_init: wb_valid=%b ex_ready=%b fflags=%b frm=%b, want 0 1 0 0", wb_valid, ex_ready, fflags, frm);
      end
      rst_n = 1'b1;
      step();
      test_reset();
      test_back_to_back();
      test_cmp_steer();
      test_flags();
      test_csr();
      test_frm_unhit();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
